// File: rtl/uart_cmd_ctrl_if.sv
// Register-write bus between the UART command controller and the
// downstream register file.
//   wr_valid : write request, held until accepted
//   wr_addr  : write address, stable while wr_valid & !wr_ready
//   wr_data  : write data, stable while wr_valid & !wr_ready
//   wr_ready : downstream accepts the write when wr_valid & wr_ready
interface uart_cmd_ctrl_if;
  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ready;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Frame-level controller behind the UART receiver. Parses frames of the form
// [SYNC][ADDR][LEN][DATA x LEN][CHK], buffers the payload and checks that the
// 8-bit sum of ADDR..CHK is zero. Only a verified frame is written out over
// the register bus, one valid/ready write per payload byte.
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_rx_valid     : one-cycle byte strobe from the UART receiver
//   i_rx_byte      : received byte
//   wr             : register-write bus (master side)
//   o_frame_ok     : pulse, frame committed
//   o_frame_err    : pulse, frame dropped
//   o_err_code     : last error (1 checksum, 2 bad length, 3 timeout)
//   o_overrun      : pulse, byte discarded because it arrived during a commit
//   o_busy         : controller is not idle
module uart_cmd_ctrl #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 43400
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_rx_valid,
  input  logic [7:0]       i_rx_byte,
  uart_cmd_ctrl_if.master  wr,
  output logic             o_frame_ok,
  output logic             o_frame_err,
  output logic [1:0]       o_err_code,
  output logic             o_overrun,
  output logic             o_busy
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_LEN, GET_DATA, GET_CHK, COMMIT
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        sum_q, sum_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              ok_q, ok_d;
  logic              err_q, err_d;
  logic [1:0]        code_q, code_d;
  logic              ovr_q, ovr_d;

  // Payload storage and frame header fields carry no reset; they are only
  // read in states reachable after being written.
  logic [7:0]        buf_mem [MAX_LEN];
  logic [7:0]        base_q;
  logic [IDX_W-1:0]  last_q;
  logic              buf_we;
  logic              base_we;
  logic              last_we;

  logic              in_frame;
  logic [7:0]        sum_in;

  assign in_frame = (state_q == GET_ADDR) || (state_q == GET_LEN) ||
                    (state_q == GET_DATA) || (state_q == GET_CHK);
  assign sum_in   = sum_q + i_rx_byte;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sum_q   <= '0;
      to_q    <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'd0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      to_q    <= to_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      code_q  <= code_d;
      ovr_q   <= ovr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (buf_we)  buf_mem[idx_q] <= i_rx_byte;
    if (base_we) base_q <= i_rx_byte;
    if (last_we) last_q <= IDX_W'(i_rx_byte - 8'd1);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    to_d    = to_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    ovr_d   = 1'b0;
    buf_we  = 1'b0;
    base_we = 1'b0;
    last_we = 1'b0;

    // Inter-byte timer; a byte on the expiry cycle wins because the
    // state case below overrides state_d only when a byte is present,
    // and expiry is only taken when no byte is present.
    if (in_frame) begin
      if (i_rx_valid) begin
        to_d = '0;
      end else if (to_q == TO_LAST) begin
        err_d   = 1'b1;
        code_d  = 2'd3;
        state_d = IDLE;
      end else begin
        to_d = to_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (i_rx_valid && (i_rx_byte == SYNC_BYTE)) begin
          state_d = GET_ADDR;
          to_d    = '0;
          idx_d   = '0;
          sum_d   = '0;
        end
      end
      GET_ADDR: begin
        if (i_rx_valid) begin
          base_we = 1'b1;
          sum_d   = i_rx_byte;
          state_d = GET_LEN;
        end
      end
      GET_LEN: begin
        if (i_rx_valid) begin
          if ((i_rx_byte == 8'd0) || (int'(i_rx_byte) > MAX_LEN)) begin
            err_d   = 1'b1;
            code_d  = 2'd2;
            state_d = IDLE;
          end else begin
            last_we = 1'b1;
            sum_d   = sum_in;
            idx_d   = '0;
            state_d = GET_DATA;
          end
        end
      end
      GET_DATA: begin
        if (i_rx_valid) begin
          buf_we = 1'b1;
          sum_d  = sum_in;
          if (idx_q == last_q) begin
            idx_d   = '0;
            state_d = GET_CHK;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      GET_CHK: begin
        if (i_rx_valid) begin
          sum_d = sum_in;
          if (sum_in == 8'd0) begin
            idx_d   = '0;
            state_d = COMMIT;
          end else begin
            err_d   = 1'b1;
            code_d  = 2'd1;
            state_d = IDLE;
          end
        end
      end
      COMMIT: begin
        // Incoming bytes are dropped, including SYNC; the commit carries on.
        if (i_rx_valid) ovr_d = 1'b1;
        if (wr.wr_ready) begin
          if (idx_q == last_q) begin
            idx_d   = '0;
            ok_d    = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Address and data depend only on idx_q, which moves only on a handshake,
  // so they hold steady while the downstream stalls.
  assign wr.wr_valid = (state_q == COMMIT);
  assign wr.wr_addr  = (state_q == COMMIT) ? (base_q + 8'(idx_q)) : 8'd0;
  assign wr.wr_data  = (state_q == COMMIT) ? buf_mem[idx_q] : 8'd0;

  assign o_frame_ok  = ok_q;
  assign o_frame_err = err_q;
  assign o_err_code  = code_q;
  assign o_overrun   = ovr_q;
  assign o_busy      = (state_q != IDLE);

endmodule
